// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences repeated operations on an external registered ALU
// Latches a command, feeds the ALU count times, then holds the result until handshaken.
module alu_sequencer #(
    parameter int N          = 16,
    parameter int width_of_i = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [7:0]   cmd_count,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    output logic [N-1:0] alu_in1,
    output logic [N-1:0] alu_in2,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_res,
    input  logic [15:0]  alu_z,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_zero,
    output logic         res_err,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_OUT, WAIT_Z, DONE} state_t;

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] acc_q, acc_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [N-1:0] in1_q, in1_d;
    logic [N-1:0] in2_q, in2_d;
    logic [N-1:0] data_q, data_d;
    logic         zero_q, zero_d;
    logic         err_q, err_d;

    // Only the LSB of the ALU flag word carries the zero flag; the shift amount lives in the ALU.
    wire logic unused_ok = (^alu_z[15:1]) ^ (width_of_i > 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 3'd7;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        data_d  = data_q;
        zero_d  = zero_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    b_d  = cmd_b;
                    if (cmd_op <= 3'd4) begin
                        cnt_d   = (cmd_count == 8'd0) ? 8'd1 : cmd_count;
                        in1_d   = cmd_a;
                        in2_d   = cmd_b;
                        state_d = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        zero_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            ISSUE: state_d = WAIT_OUT;
            WAIT_OUT: begin
                acc_d = alu_res;
                cnt_d = cnt_q - 8'd1;
                if (cnt_q > 8'd1) begin
                    // Operands are registered here so they are already stable during ISSUE.
                    in1_d   = alu_res;
                    in2_d   = b_q;
                    state_d = ISSUE;
                end else begin
                    state_d = WAIT_Z;
                end
            end
            WAIT_Z: begin
                // The ALU's zero flag trails alu_out by a cycle, hence this extra state.
                data_d  = acc_q;
                zero_d  = alu_z[0];
                err_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign alu_op    = (state_q == ISSUE) ? op_q : 3'd7;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign res_data  = data_q;
    assign res_zero  = zero_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a registered ALU model
module tb_alu_sequencer;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [7:0]   cmd_count = '0;
    logic [N-1:0] cmd_a = '0;
    logic [N-1:0] cmd_b = '0;
    logic [N-1:0] alu_in1, alu_in2;
    logic [2:0]   alu_op;
    logic [N-1:0] alu_out = '0;
    logic [15:0]  alu_z = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] res_data;
    logic         res_zero, res_err, busy;

    int vectors = 0;
    int miscompares = 0;

    alu_sequencer #(.N(N), .width_of_i(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_res(alu_out), .alu_z(alu_z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] alu_calc(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        case (op)
            3'd0:    return x;
            3'd1:    return x + y;
            3'd2:    return x - y;
            3'd3:    return x * y;
            3'd4:    return x << W;
            default: return x;
        endcase
    endfunction

    // Registered ALU: op 7 holds alu_out, zero flag trails alu_out by one edge.
    always @(posedge clk) begin
        if (alu_op != 3'd7) alu_out <= alu_calc(alu_op, alu_in1, alu_in2);
        alu_z <= {15'd0, alu_out == '0};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
    task automatic run_cmd(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [7:0] cnt, input int hold);
        int n, last;
        logic legal;
        logic [N-1:0] r, expd;
        n     = (cnt == 8'd0) ? 1 : int'(cnt);
        legal = (op <= 3'd4);
        last  = legal ? 2 * n + 1 : 0;
        expd  = '0;
        if (legal) begin
            expd = a;
            repeat (n) expd = alu_calc(op, expd, b);
        end
        r = a;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_count = cnt;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < last; k++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 3'($urandom); cmd_a = N'($urandom); cmd_b = N'($urandom); cmd_count = 8'($urandom);
            chk("busy", busy, 1'b1);
            chk("cmd_ready_busy", cmd_ready, 1'b0);
            chk("res_valid_early", res_valid, 1'b0);
            if (k < 2 * n && k % 2 == 0) begin
                chk("alu_op_issue", alu_op, op);
                chk("alu_in1", alu_in1, r);
                chk("alu_in2", alu_in2, b);
                r = alu_calc(op, r, b);
            end else begin
                chk("alu_op_hold", alu_op, 3'd7);
            end
            @(posedge clk); @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("res_valid", res_valid, 1'b1);
        chk("alu_op_done", alu_op, 3'd7);
        chk("res_data", res_data, expd);
        chk("res_zero", res_zero, legal && expd == '0);
        chk("res_err", res_err, !legal);
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_data", res_data, expd);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        res_ready = 1'b0;
        chk("back_idle_ready", cmd_ready, 1'b1);
        chk("back_idle_valid", res_valid, 1'b0);
        chk("back_idle_busy", busy, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_alu_op", alu_op, 3'd7);
        chk("rst_res_data", res_data, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(3'd1, 16'd5, 16'd7, 8'd1, 0);
        run_cmd(3'd2, 16'd9, 16'd3, 8'd3, 1);
        run_cmd(3'd3, 16'h0100, 16'h0100, 8'd1, 0);
        run_cmd(3'd4, 16'h0001, 16'h1234, 8'd2, 2);
        run_cmd(3'd5, 16'h00ff, 16'h0001, 8'd3, 0);
        run_cmd(3'd0, 16'hbeef, 16'h0001, 8'd0, 0);
        run_cmd(3'd7, 16'h0000, 16'h0000, 8'd0, 1);
        run_cmd(3'd1, 16'hffff, 16'h0001, 8'd1, 10);

        // Reset while an add with count 4 is in its first WAIT_OUT.
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 16'd10; cmd_b = 16'd20; cmd_count = 8'd4;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_cmd_ready", cmd_ready, 1'b1);
        chk("arst_res_valid", res_valid, 1'b0);
        chk("arst_alu_op", alu_op, 3'd7);
        chk("arst_alu_in1", alu_in1, 16'd0);
        chk("arst_alu_in2", alu_in2, 16'd0);
        chk("arst_res_data", res_data, 16'd0);
        chk("arst_res_zero", res_zero, 1'b0);
        chk("arst_res_err", res_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        run_cmd(3'd1, 16'd1, 16'd1, 8'd0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [2:0] rop;
            rop = ($urandom_range(0, 7) == 0) ? 3'(5 + $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            run_cmd(rop, N'($urandom), N'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                    8'($urandom_range(0, 5)), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, data width, identical to the downstream ALU's N.
REQ-002 SHALL have parameter width_of_i, default 4, shift amount of ALU op 4; used only for documenting expected results.
REQ-003 SHALL have one clock; reset is asynchronous and active-high: clk input 1 (rising edge), rst input 1 (async, active-high).
REQ-004 cmd_valid input 1, command offered; cmd_ready output 1, command accepted when both are high at a clk edge.
REQ-005 cmd_op input 3, ALU opcode (0 pass in1, 1 add, 2 sub, 3 mul, 4 shift-left by width_of_i); cmd_count input 8, iteration count.
REQ-006 cmd_a input N, first operand; cmd_b input N, second operand.
REQ-007 alu_in1 output N, alu_in2 output N, alu_op output 3, drive the ALU's in1, in2 and alu_op.
REQ-008 alu_res input N, the ALU's alu_out; alu_z input 16, the ALU's z flag word.
REQ-009 res_valid output 1, res_ready input 1, result handshake; res_data output N; res_zero output 1; res_err output 1.
REQ-010 busy output 1, high in every state except IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, ISSUE, WAIT_OUT, WAIT_Z and DONE, all registered on clk.
REQ-012 cmd_ready SHALL be 1 only in IDLE; an accepted command latches op, a, b and count, with count 0 treated as 1.
REQ-013 IDLE accept with legal op (0-4): next state ISSUE, iteration counter = count.
REQ-014 IDLE accept with op 5-7: next state DONE, res_err=1, res_data=0, res_zero=0, no ALU op issued.
REQ-015 In ISSUE: alu_op=latched op, alu_in2=b, alu_in1=a on first iteration, else acc; next state WAIT_OUT.
REQ-016 In all states except ISSUE: alu_op=3'd7 (ALU holds alu_out); alu_in1 and alu_in2 hold their last values.
REQ-017 In WAIT_OUT: acc<=alu_res, counter decrements; if counter >1 next ISSUE, else next WAIT_Z.
REQ-018 In WAIT_Z: res_data<=acc, res_zero<=alu_z[0], res_err<=0; next DONE (z lags alu_out by one cycle).
REQ-019 In DONE: res_valid=1 and res_data/res_zero/res_err stable; res_valid&&res_ready moves to IDLE; res_ready low holds DONE indefinitely.
REQ-020 Latency: res_valid SHALL rise 2*count+1 edges after the accept edge (count 0 counts as 1); it is 1 edge for illegal ops.
REQ-021 Arithmetic SHALL be done by the ALU only; results are N bits and wrap modulo 2^N, with no widening or saturation.
REQ-022 No new command is accepted before the DONE handshake completes; cmd_valid outside IDLE is ignored.

Reset
REQ-023 rst high SHALL force asynchronously: state IDLE, res_valid 0, res_data 0, res_zero 0, res_err 0, acc 0, counter 0, alu_op 3'd7, alu_in1 0, alu_in2 0, busy 0.
REQ-024 Reset mid-operation SHALL abandon the command with no result; cmd_ready=1 in the first cycle after rst deasserts.

Verification (N=16, width_of_i=4)
REQ-025 add a=5 b=7 count=1 -> res_data=12, res_zero=0, res_valid 3 edges after accept.
REQ-026 sub a=9 b=3 count=3 -> res_data=0, res_zero=1, res_valid 7 edges after accept; alu_op sequence 2,7,2,7,2,7,7.
REQ-027 mul a=0x0100 b=0x0100 count=1 -> res_data=0x0000 (wrap), res_zero=1; shift a=0x0001 count=2 -> res_data=0x0100.
REQ-028 cmd_op=5 -> res_valid 1 edge after accept, res_err=1, res_data=0; alu_op stays 3'd7 throughout.
REQ-029 res_ready held low 10 cycles in DONE -> res_valid and res_data stable, cmd_ready 0, and a cmd_valid pulse is not accepted; release -> IDLE next edge.
REQ-030 rst pulse during WAIT_OUT of a count=4 add -> all outputs at reset values immediately; a new add a=1 b=1 count=0 -> res_data=2.
